rtu_prio_arb: RTL and testbench
===============================

// Module: rtu_prio_arb
//
// PURPOSE
//   Parametrised N-input request arbiter with a registered grant and a valid/ready handshake.
//   Next generation of the fixed 6-input priority encoder (index + valid output).
//   Adds runtime-selectable fixed-priority or round-robin mode.
//   Grant is held stable until the consumer accepts it.
//   Sits between a bank of requesters and a single shared resource / consumer.
//
// PARAMETERS
//   N    8                          number of request lines, N >= 2, need not be a power of two
//   IW   $clog2(N) (localparam)     width of grant index
//
// PORTS
//   clk       in   1    system clock, all state updates on posedge
//   rst_b     in   1    asynchronous, active-low reset
//   req       in   N    request vector, bit k = requester k wants the resource
//   rr_en     in   1    0 = fixed priority, 1 = round-robin; sampled at each arbitration
//   gnt_rdy   in   1    consumer accepts the current grant
//   gnt_vld   out  1    grant outputs valid
//   gnt_idx   out  IW   index of granted requester
//   gnt_oh    out  N    one-hot grant, equals (1 << gnt_idx) when gnt_vld=1, else 0
//
// BEHAVIOUR
//   Reset (rst_b=0, asynchronous):
//     - gnt_vld=0, gnt_idx=0, gnt_oh=0, rr pointer ptr=0, state IDLE.
//     - Applies immediately, including mid-grant; a held grant is dropped, not replayed.
//   States:
//     - IDLE: no grant outstanding.
//     - GRANT: gnt_vld=1, outputs frozen.
//   Arbitration (combinational winner W from req, rr_en, ptr):
//     - fixed (rr_en=0): lowest set index of req wins (bit 0 highest priority).
//     - round-robin (rr_en=1): first set bit searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//   IDLE:
//     - req != 0 -> next cycle state=GRANT, gnt_idx=W, gnt_oh=1<<W, gnt_vld=1 (latency 1 clk).
//     - req == 0 -> stay IDLE, outputs remain 0/unchanged (gnt_idx holds last value).
//   GRANT, gnt_rdy=0:
//     - all outputs held stable, regardless of changes on req or rr_en.
//     - Grant is sticky even if the granted requester deasserts.
//   GRANT, gnt_rdy=1 (accept):
//     - ptr <= (gnt_idx == N-1) ? 0 : gnt_idx+1, updated in both modes.
//     - Re-arbitrate in the same cycle on current req using the updated ptr value
//       (next-ptr, combinational).
//     - req != 0 -> stay GRANT, new grant presented next cycle.
//       Back-to-back: one grant per clock.
//     - req == 0 -> IDLE, gnt_vld=0, gnt_oh=0 next cycle.
//   Fairness / stability rules:
//     - fixed mode: the just-accepted requester may win again if still highest.
//     - round-robin: the just-accepted requester has lowest priority next round.
//     - ptr wraps from N-1 to 0; for non-power-of-two N, ptr never exceeds N-1.
//   Other rules:
//     - gnt_rdy while IDLE is ignored.
//     - Mode change while in GRANT takes effect at the next arbitration only.
//     - Invariant: gnt_vld=1 implies exactly one bit of gnt_oh set and gnt_idx < N.
//
// TESTING (N=8 unless stated)
//   1. Reset:
//      rst_b=0 asynchronously mid-grant (gnt_vld=1)
//      -> gnt_vld, gnt_oh, gnt_idx go 0 without waiting for clk;
//         after release with req=0, stays IDLE.
//   2. Fixed priority, hold:
//      rr_en=0, req=8'hA4
//      -> next clk gnt_idx=2, gnt_oh=8'h04, gnt_vld=1.
//      Then gnt_rdy=0 for 3 clks while req changes to 8'h80 -> outputs unchanged.
//      Then gnt_rdy=1 -> next clk gnt_idx=7.
//   3. Round-robin back-to-back:
//      rr_en=1, req=8'hFF, gnt_rdy=1 constant
//      -> grants 0,1,2,...,7,0 on consecutive clks, gnt_vld never drops.
//   4. RR wrap / skip:
//      After accepting idx 5 (ptr=6), req=8'h03
//      -> grant 0, then after accept ptr=1 and grant 1.
//   5. Non-power-of-two N=5:
//      rr_en=1, req=5'b10001, gnt_rdy=1
//      -> grants alternate 0,4,0,4; ptr takes only values 0..4.
//   6. Drain:
//      In GRANT with req=0 and gnt_rdy=1
//      -> next clk gnt_vld=0, gnt_oh=0, state IDLE.
//      Further gnt_rdy pulses cause no change.

Source files
------------

// File: rtl/rtu_prio_arb_if.sv
// Request/grant bundle between a bank of requesters and the rtu_prio_arb arbiter.
// The master side drives the requests and accepts grants; the slave side is the arbiter.
interface rtu_prio_arb_if #(
    parameter int N = 8
);
    localparam int IW = $clog2(N);

    logic [N-1:0]  req;
    logic          rr_en;
    logic          gnt_rdy;
    logic          gnt_vld;
    logic [IW-1:0] gnt_idx;
    logic [N-1:0]  gnt_oh;

    modport master (
        output req,
        output rr_en,
        output gnt_rdy,
        input  gnt_vld,
        input  gnt_idx,
        input  gnt_oh
    );

    modport slave (
        input  req,
        input  rr_en,
        input  gnt_rdy,
        output gnt_vld,
        output gnt_idx,
        output gnt_oh
    );
endinterface

// File: rtl/rtu_prio_arb.sv
// N-input arbiter, fixed-priority or round-robin, with a registered grant that is
// held until the consumer accepts it; accept and re-arbitration happen in one cycle.
module rtu_prio_arb #(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst_b,
    rtu_prio_arb_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam logic [IW:0]   N_W      = (IW+1)'(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [IW-1:0] ptr_r;
    logic [IW-1:0] ptr_nxt_s;
    logic          gnt_vld_r;
    logic          gnt_vld_nxt_s;
    logic [IW-1:0] gnt_idx_r;
    logic [IW-1:0] gnt_idx_nxt_s;
    logic [N-1:0]  gnt_oh_r;
    logic [N-1:0]  gnt_oh_nxt_s;
    logic          accept_s;
    logic [IW-1:0] start_s;
    logic [IW:0]   win_s;
    logic          win_found_s;
    logic [IW-1:0] win_idx_s;
    logic [N-1:0]  win_oh_s;

    // First set request searching circularly from start; MSB of the result flags a hit.
    function automatic logic [IW:0] pick_winner(input logic [N-1:0] req_v,
                                                input logic [IW-1:0] start_v);
        logic          found_v;
        logic [IW-1:0] idx_v;
        logic [IW:0]   j_v;
        found_v = 1'b0;
        idx_v   = {IW{1'b0}};
        for (int i = 0; i < N; i++) begin
            j_v = {1'b0, start_v} + (IW+1)'(i);
            if (j_v >= N_W) begin
                j_v = j_v - N_W;
            end else begin
                j_v = j_v;
            end
            if (!found_v && req_v[j_v[IW-1:0]]) begin
                found_v = 1'b1;
                idx_v   = j_v[IW-1:0];
            end else begin
                found_v = found_v;
            end
        end
        return {found_v, idx_v};
    endfunction

    // Pointer advance on accept and winner selection using the advanced pointer.
    always_comb begin
        accept_s  = (state_r == GRANT) && bus.gnt_rdy;
        ptr_nxt_s = ptr_r;
        if (accept_s) begin
            ptr_nxt_s = (gnt_idx_r == LAST_IDX) ? {IW{1'b0}} : gnt_idx_r + {{(IW-1){1'b0}}, 1'b1};
        end else begin
            ptr_nxt_s = ptr_r;
        end
        start_s     = bus.rr_en ? ptr_nxt_s : {IW{1'b0}};
        win_s       = pick_winner(bus.req, start_s);
        win_found_s = win_s[IW];
        win_idx_s   = win_s[IW-1:0];
        win_oh_s    = {{(N-1){1'b0}}, 1'b1} << win_idx_s;
    end

    // Next-state and next-output decode; outputs are frozen while a grant waits.
    always_comb begin
        state_nxt_s   = state_r;
        gnt_vld_nxt_s = gnt_vld_r;
        gnt_idx_nxt_s = gnt_idx_r;
        gnt_oh_nxt_s  = gnt_oh_r;
        case (state_r)
            IDLE: begin
                if (win_found_s) begin
                    state_nxt_s   = GRANT;
                    gnt_vld_nxt_s = 1'b1;
                    gnt_idx_nxt_s = win_idx_s;
                    gnt_oh_nxt_s  = win_oh_s;
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            GRANT: begin
                if (accept_s && win_found_s) begin
                    state_nxt_s   = GRANT;
                    gnt_vld_nxt_s = 1'b1;
                    gnt_idx_nxt_s = win_idx_s;
                    gnt_oh_nxt_s  = win_oh_s;
                end else if (accept_s) begin
                    state_nxt_s   = IDLE;
                    gnt_vld_nxt_s = 1'b0;
                    gnt_oh_nxt_s  = {N{1'b0}};
                end else begin
                    state_nxt_s   = GRANT;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                gnt_vld_nxt_s = 1'b0;
                gnt_idx_nxt_s = {IW{1'b0}};
                gnt_oh_nxt_s  = {N{1'b0}};
            end
        endcase
    end

    // State, pointer and grant registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r   <= IDLE;
            ptr_r     <= {IW{1'b0}};
            gnt_vld_r <= 1'b0;
            gnt_idx_r <= {IW{1'b0}};
            gnt_oh_r  <= {N{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            ptr_r     <= ptr_nxt_s;
            gnt_vld_r <= gnt_vld_nxt_s;
            gnt_idx_r <= gnt_idx_nxt_s;
            gnt_oh_r  <= gnt_oh_nxt_s;
        end
    end

    assign bus.gnt_vld = gnt_vld_r;
    assign bus.gnt_idx = gnt_idx_r;
    assign bus.gnt_oh  = gnt_oh_r;
endmodule

// File: tb/tb_rtu_prio_arb.sv
// Bench for rtu_prio_arb: an 8-input and a 5-input instance, accepted grants
// checked against queued expectations, plus direct checks of hold, drain and reset.
module tb_rtu_prio_arb;
    logic clk;
    logic rst_b;
    int   total;
    int   bad;
    int   exp8[$];
    int   exp5[$];

    rtu_prio_arb_if #(.N(8)) a8 ();
    rtu_prio_arb_if #(.N(5)) a5 ();

    rtu_prio_arb #(.N(8)) u_dut8 (.clk(clk), .rst_b(rst_b), .bus(a8.slave));
    rtu_prio_arb #(.N(5)) u_dut5 (.clk(clk), .rst_b(rst_b), .bus(a5.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total = total + 1;
        if (act !== exp_v) begin
            bad = bad + 1;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pops one expectation per accepted grant (vld && rdy at the falling edge).
    task automatic monitor();
        int e;
        logic [31:0] one_v;
        one_v = 32'd1;
        forever begin
            @(negedge clk);
            if (a8.gnt_vld && a8.gnt_rdy) begin
                if (exp8.size() == 0) begin
                    chk("n8_unexpected_grant", 32'(a8.gnt_idx), 32'hFFFF_FFFF);
                end else begin
                    e = exp8.pop_front();
                    chk("n8_gnt_idx", 32'(a8.gnt_idx), 32'(e));
                    chk("n8_gnt_oh", 32'(a8.gnt_oh), one_v << e);
                end
            end
            if (a5.gnt_vld && a5.gnt_rdy) begin
                if (exp5.size() == 0) begin
                    chk("n5_unexpected_grant", 32'(a5.gnt_idx), 32'hFFFF_FFFF);
                end else begin
                    e = exp5.pop_front();
                    chk("n5_gnt_idx", 32'(a5.gnt_idx), 32'(e));
                    chk("n5_gnt_oh", 32'(a5.gnt_oh), one_v << e);
                end
            end
        end
    endtask

    task automatic chk8(input string name, input logic vld, input int idx, input int oh);
        chk({name, "_vld"}, 32'(a8.gnt_vld), 32'(vld));
        chk({name, "_idx"}, 32'(a8.gnt_idx), 32'(idx));
        chk({name, "_oh"},  32'(a8.gnt_oh),  32'(oh));
    endtask

    initial begin
        clk   = 1'b0;
        rst_b = 1'b0;
        total = 0;
        bad   = 0;
        a8.req = 8'h00; a8.rr_en = 1'b0; a8.gnt_rdy = 1'b0;
        a5.req = 5'h00; a5.rr_en = 1'b0; a5.gnt_rdy = 1'b0;
        fork
            monitor();
        join_none

        // reset state and idle after release
        repeat (2) step();
        #2 chk8("reset", 1'b0, 0, 0);
        step(); rst_b = 1'b1;
        step(); step();
        #2 chk8("idle_after_reset", 1'b0, 0, 0);

        // fixed priority, sticky grant while gnt_rdy is low
        step(); a8.req = 8'hA4; a8.rr_en = 1'b0; a8.gnt_rdy = 1'b0;
        step(); #2 chk8("fixed_first", 1'b1, 2, 8'h04);
        a8.req = 8'h80;
        for (int i = 0; i < 3; i++) begin
            step(); #2 chk8("fixed_hold", 1'b1, 2, 8'h04);
        end
        exp8.push_back(2);
        exp8.push_back(7);
        a8.gnt_rdy = 1'b1;
        step(); #2 a8.req = 8'h00;
        step(); #2 chk8("drain", 1'b0, 7, 0);
        for (int i = 0; i < 3; i++) begin
            a8.gnt_rdy = 1'b0;
            step();
            a8.gnt_rdy = 1'b1;
            step(); #2 chk8("idle_rdy_ignored", 1'b0, 7, 0);
        end

        // round-robin back-to-back, then wrap/skip with req=03 after accepting 5
        a8.rr_en = 1'b1;
        for (int k = 0; k < 8; k++) exp8.push_back(k);
        for (int k = 0; k < 6; k++) exp8.push_back(k);
        exp8.push_back(0);
        exp8.push_back(1);
        a8.req = 8'hFF;
        for (int i = 0; i < 14; i++) begin
            step(); #2 chk("rr_b2b_vld", 32'(a8.gnt_vld), 32'd1);
            if (i == 13) a8.req = 8'h03;
        end
        step(); #2 chk("rr_wrap_vld", 32'(a8.gnt_vld), 32'd1);
        step(); #2 chk("rr_skip_vld", 32'(a8.gnt_vld), 32'd1);
        a8.req = 8'h00;
        step(); #2 chk8("rr_drain", 1'b0, 1, 0);

        // asynchronous reset in the middle of a held grant
        a8.rr_en = 1'b0; a8.gnt_rdy = 1'b0; a8.req = 8'h10;
        step(); #2 chk8("pre_reset_grant", 1'b1, 4, 8'h10);
        rst_b = 1'b0;
        #1 chk8("async_reset", 1'b0, 0, 0);
        a8.req = 8'h00;
        step(); step(); rst_b = 1'b1;
        step(); step();
        #2 chk8("idle_after_mid_reset", 1'b0, 0, 0);

        // pointer must be back at 0: rr with req=06 grants 1, not 2
        a8.rr_en = 1'b1; a8.req = 8'h06; a8.gnt_rdy = 1'b1;
        exp8.push_back(1);
        step(); #2 a8.req = 8'h00;
        step(); #2 chk("ptr_reset_drain_vld", 32'(a8.gnt_vld), 32'd0);

        // N=5 round-robin alternating between the two end requesters
        a5.rr_en = 1'b1; a5.gnt_rdy = 1'b1;
        exp5.push_back(0); exp5.push_back(4); exp5.push_back(0); exp5.push_back(4);
        a5.req = 5'b10001;
        step(); #2 chk("n5_vld", 32'(a5.gnt_vld), 32'd1);
        step(); step(); step();
        #2 a5.req = 5'b00000;
        step(); #2 chk("n5_drain_vld", 32'(a5.gnt_vld), 32'd0);

        step();
        chk("n8_queue_empty", 32'(exp8.size()), 32'd0);
        chk("n5_queue_empty", 32'(exp5.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
